// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB update-port controller: two-port RR arbiter, update FIFO, flush walk
module btb_update_ctrl #(
  parameter int SETS       = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          upd0_valid_i,
  output logic                          upd0_ready_o,
  input  logic [63:0]                   upd0_pc_i,
  input  logic [63:0]                   upd0_target_i,
  input  logic                          upd0_taken_i,
  input  logic                          upd1_valid_i,
  output logic                          upd1_ready_o,
  input  logic [63:0]                   upd1_pc_i,
  input  logic [63:0]                   upd1_target_i,
  input  logic                          upd1_taken_i,
  input  logic                          fetch_req_i,
  input  logic                          flush_i,
  output logic                          flush_busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          btb_update_valid_o,
  output logic [63:0]                   btb_update_pc_o,
  output logic [63:0]                   btb_update_target_o,
  output logic                          btb_update_taken_o
);

  localparam int IW = $clog2(SETS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t                state_q;
  logic [IW-1:0]         walk_q;
  logic                  rr_q;
  logic [PW-1:0]         wr_q;
  logic [PW-1:0]         rd_q;
  logic [CW-1:0]         count_q;

  logic [63:0]           q_pc  [FIFO_DEPTH];
  logic [63:0]           q_tgt [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_taken;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  can_push;
  logic                  grant1;
  logic                  push;
  logic                  pop;
  logic [IW-1:0]         walk_next;

  assign fifo_full    = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty   = (count_q == '0);
  assign fifo_count_o = count_q;
  assign walk_next    = walk_q + 1'b1;

  // Pushes are blocked while flushing (or starting a flush) and when full; no full bypass.
  assign can_push = (state_q == S_IDLE) && !flush_i && !fifo_full;

  // Port 1 wins when it is the only requester or when the RR pointer favours it.
  always_comb begin
    grant1 = upd1_valid_i && (!upd0_valid_i || rr_q);
  end

  assign upd0_ready_o = can_push && upd0_valid_i && !grant1;
  assign upd1_ready_o = can_push && grant1;
  assign push         = upd0_ready_o || upd1_ready_o;

  // Lookups defer draining unless the queue is full, which keeps the backend from starving.
  assign pop = (state_q == S_IDLE) && !flush_i && !fifo_empty && (!fetch_req_i || fifo_full);

  // Queue payload storage; contents are qualified by the pointers so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_q]    <= grant1 ? upd1_pc_i     : upd0_pc_i;
      q_tgt[wr_q]   <= grant1 ? upd1_target_i : upd0_target_i;
      q_taken[wr_q] <= grant1 ? upd1_taken_i  : upd0_taken_i;
    end
  end

  // Queue pointers and occupancy; a flush discards everything still queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (state_q == S_IDLE && flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Round-robin pointer only advances after a grant made while both ports were requesting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else if (push && upd0_valid_i && upd1_valid_i) begin
      rr_q <= !grant1;
    end
  end

  // Control FSM with registered BTB update outputs: queue drain in IDLE, invalidation walk in FLUSH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= S_IDLE;
      walk_q              <= '0;
      flush_busy_o        <= 1'b0;
      btb_update_valid_o  <= 1'b0;
      btb_update_pc_o     <= '0;
      btb_update_target_o <= '0;
      btb_update_taken_o  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush_i) begin
            state_q             <= S_FLUSH;
            walk_q              <= '0;
            flush_busy_o        <= 1'b1;
            btb_update_valid_o  <= 1'b1;
            btb_update_pc_o     <= '0;
            btb_update_target_o <= '0;
            btb_update_taken_o  <= 1'b0;
          end else begin
            btb_update_valid_o <= pop;
            if (pop) begin
              btb_update_pc_o     <= q_pc[rd_q];
              btb_update_target_o <= q_tgt[rd_q];
              btb_update_taken_o  <= q_taken[rd_q];
            end
          end
        end
        S_FLUSH: begin
          if (walk_q == IW'(SETS - 1)) begin
            state_q            <= S_IDLE;
            flush_busy_o       <= 1'b0;
            btb_update_valid_o <= 1'b0;
          end else begin
            walk_q              <= walk_next;
            btb_update_valid_o  <= 1'b1;
            btb_update_pc_o     <= 64'({walk_next, 2'b00});
            btb_update_target_o <= '0;
            btb_update_taken_o  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - directed self-checking bench for btb_update_ctrl
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd0_valid_i, upd1_valid_i;
  logic        upd0_ready_o, upd1_ready_o;
  logic [63:0] upd0_pc_i, upd0_target_i, upd1_pc_i, upd1_target_i;
  logic        upd0_taken_i, upd1_taken_i;
  logic        fetch_req_i, flush_i;
  logic        flush_busy_o;
  logic [2:0]  fifo_count_o;
  logic        btb_update_valid_o;
  logic [63:0] btb_update_pc_o, btb_update_target_o;
  logic        btb_update_taken_o;

  btb_update_ctrl #(.SETS(4096), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd0_valid_i(upd0_valid_i), .upd0_ready_o(upd0_ready_o), .upd0_pc_i(upd0_pc_i),
    .upd0_target_i(upd0_target_i), .upd0_taken_i(upd0_taken_i),
    .upd1_valid_i(upd1_valid_i), .upd1_ready_o(upd1_ready_o), .upd1_pc_i(upd1_pc_i),
    .upd1_target_i(upd1_target_i), .upd1_taken_i(upd1_taken_i),
    .fetch_req_i(fetch_req_i), .flush_i(flush_i), .flush_busy_o(flush_busy_o),
    .fifo_count_o(fifo_count_o), .btb_update_valid_o(btb_update_valid_o),
    .btb_update_pc_o(btb_update_pc_o), .btb_update_target_o(btb_update_target_o),
    .btb_update_taken_o(btb_update_taken_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] tgt;
    logic        tk;
  } strobe_t;

  strobe_t seen[$];
  int      n_chk  = 0;
  int      n_pass = 0;

  // record every update strobe presented to the BTB
  always @(negedge clk) begin
    if (btb_update_valid_o) seen.push_back('{btb_update_pc_o, btb_update_target_o, btb_update_taken_o});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] exp_pc[4];
    logic [7:0]  exp_rdy;
    logic [2:0]  exp_cnt[8];
    int          k;
    int          walk_err;
    int          rdy_err;

    rst_n = 1'b0;
    upd0_valid_i = 0; upd1_valid_i = 0;
    upd0_pc_i = 0; upd0_target_i = 0; upd0_taken_i = 0;
    upd1_pc_i = 0; upd1_target_i = 0; upd1_taken_i = 0;
    fetch_req_i = 0; flush_i = 0;

    // reset state
    repeat (2) step();
    chk("rst_valid", btb_update_valid_o, 0);
    chk("rst_pc", btb_update_pc_o, 0);
    chk("rst_busy", flush_busy_o, 0);
    chk("rst_count", fifo_count_o, 0);
    rst_n = 1'b1;
    step();

    // single update: strobe two cycles after acceptance
    seen.delete();
    upd0_valid_i = 1; upd0_pc_i = 64'h1000; upd0_target_i = 64'h2000; upd0_taken_i = 1;
    @(negedge clk);
    chk("single_rdy", {upd1_ready_o, upd0_ready_o}, 2'b01);
    step();
    upd0_valid_i = 0;
    @(negedge clk);
    chk("single_cnt1", fifo_count_o, 1);
    chk("single_v1", btb_update_valid_o, 0);
    step();
    @(negedge clk);
    chk("single_v2", btb_update_valid_o, 1);
    chk("single_pc", btb_update_pc_o, 64'h1000);
    chk("single_tgt", btb_update_target_o, 64'h2000);
    chk("single_tk", btb_update_taken_o, 1);
    chk("single_cnt2", fifo_count_o, 0);
    step();
    @(negedge clk);
    chk("single_v3", btb_update_valid_o, 0);
    step();

    // contention: grants alternate 0,1,0,1
    seen.delete();
    for (int c = 0; c < 4; c++) begin
      upd0_valid_i = 1; upd0_pc_i = 64'h10000 + 64'(16 * c); upd0_target_i = upd0_pc_i + 64'h800; upd0_taken_i = 1;
      upd1_valid_i = 1; upd1_pc_i = 64'h20000 + 64'(16 * c); upd1_target_i = upd1_pc_i + 64'h800; upd1_taken_i = 0;
      exp_pc[c] = (c % 2 == 1) ? upd1_pc_i : upd0_pc_i;
      @(negedge clk);
      chk($sformatf("rr_grant%0d", c), {upd1_ready_o, upd0_ready_o}, (c % 2 == 1) ? 2'b10 : 2'b01);
      step();
    end
    upd0_valid_i = 0; upd1_valid_i = 0;
    repeat (4) step();
    chk("rr_nstrobes", seen.size(), 4);
    for (int c = 0; c < 4 && c < seen.size(); c++) begin
      chk($sformatf("rr_pc%0d", c), seen[c].pc, exp_pc[c]);
      chk($sformatf("rr_tk%0d", c), seen[c].tk, (c % 2 == 1) ? 1'b0 : 1'b1);
    end

    // lookup backpressure: fill to 4, then one drain per cycle while full
    seen.delete();
    fetch_req_i = 1;
    exp_rdy = 8'b1010_1111;
    exp_cnt = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd3};
    k = 0;
    for (int c = 0; c < 8; c++) begin
      upd0_valid_i = (k < 6); upd0_pc_i = 64'h3000 + 64'(16 * k); upd0_target_i = 64'h7000 + 64'(k); upd0_taken_i = 1;
      @(negedge clk);
      chk($sformatf("bp_rdy%0d", c), upd0_ready_o, exp_rdy[c]);
      chk($sformatf("bp_cnt%0d", c), fifo_count_o, exp_cnt[c]);
      if (upd0_valid_i && upd0_ready_o) k++;
      step();
    end
    chk("bp_accepted", k, 6);
    upd0_valid_i = 0; fetch_req_i = 0;
    repeat (6) step();
    chk("bp_nstrobes", seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++) begin
      chk($sformatf("bp_pc%0d", i), seen[i].pc, 64'h3000 + 64'(16 * i));
    end

    // flush with three queued entries, second flush and valid requests mid-walk
    fetch_req_i = 1;
    for (int i = 0; i < 3; i++) begin
      upd0_valid_i = 1; upd0_pc_i = 64'h4000 + 64'(16 * i); upd0_taken_i = 1;
      step();
    end
    upd1_valid_i = 1; upd1_pc_i = 64'h9000; upd1_taken_i = 1;
    flush_i = 1;
    @(negedge clk);
    chk("fl_cnt_pre", fifo_count_o, 3);
    chk("fl_rdy_n", {upd1_ready_o, upd0_ready_o}, 2'b00);
    step();
    flush_i = 0;
    seen.delete();
    walk_err = 0;
    rdy_err = 0;
    for (int i = 0; i < 4096; i++) begin
      flush_i = (i == 10);
      @(negedge clk);
      if (!flush_busy_o || !btb_update_valid_o || btb_update_pc_o != 64'(i * 4) ||
          btb_update_target_o != 0 || btb_update_taken_o) walk_err++;
      if (upd0_ready_o || upd1_ready_o) rdy_err++;
      if (i == 0) begin
        chk("fl_cnt_clr", fifo_count_o, 0);
        chk("fl_first_pc", btb_update_pc_o, 0);
      end
      if (i == 4095) chk("fl_last_pc", btb_update_pc_o, 64'h3FFC);
      step();
    end
    chk("fl_walk_err", walk_err, 0);
    chk("fl_rdy_err", rdy_err, 0);
    flush_i = 0; upd1_valid_i = 0; fetch_req_i = 0;
    upd0_valid_i = 1; upd0_pc_i = 64'h5000; upd0_target_i = 64'h6000; upd0_taken_i = 1;
    @(negedge clk);
    chk("fl_busy_end", flush_busy_o, 0);
    chk("fl_valid_end", btb_update_valid_o, 0);
    chk("fl_rdy_end", upd0_ready_o, 1);
    step();
    upd0_valid_i = 0;
    repeat (4) step();
    chk("fl_nstrobes", seen.size(), 4097);
    if (seen.size() == 4097) chk("fl_post_pc", seen[4096].pc, 64'h5000);

    // asynchronous reset at walk index 100
    flush_i = 1;
    step();
    flush_i = 0;
    repeat (100) step();
    #1;
    chk("ar_pre_pc", btb_update_pc_o, 64'h190);
    chk("ar_pre_busy", flush_busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", btb_update_valid_o, 0);
    chk("ar_pc", btb_update_pc_o, 0);
    chk("ar_busy", flush_busy_o, 0);
    chk("ar_cnt", fifo_count_o, 0);
    step();
    step();
    rst_n = 1'b1;
    seen.delete();
    repeat (5) step();
    chk("ar_nstrobes", seen.size(), 0);
    chk("ar_busy_post", flush_busy_o, 0);
    chk("ar_cnt_post", fifo_count_o, 0);
    upd0_valid_i = 1; upd0_pc_i = 64'h8000;
    @(negedge clk);
    chk("ar_rdy_post", upd0_ready_o, 1);
    step();
    upd0_valid_i = 0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
